fa_cache_array: RTL and testbench

FA_CACHE_ARRAY -- requirements
Module: fa_cache_array

---
 rtl/fa_cache_pkg.sv | 21 ++
 rtl/fa_cache_lru.sv | 39 +++
 rtl/fa_cache_array.sv | 198 +++++++++++++++++++
 tb/tb_fa_cache_array.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_cache_pkg.sv
// Shared types and sizing helpers for the fully associative cache array.
package fa_cache_pkg;

    // Flush scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } flush_state_e;

    // Line count assumed when a design does not override it.
    localparam int unsigned DEF_NUM_LINES = 8;

    // Width of an LRU age / line index; never narrower than one bit.
    function automatic int unsigned age_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_AGE_W = age_w(DEF_NUM_LINES);

endpackage

// File: rtl/fa_cache_lru.sv
// True-LRU age tracker: every line carries a distinct age, 0 = most recent,
// NUM_LINES-1 = least recent (the replacement victim).
module fa_cache_lru
    import fa_cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    localparam int AGE_W    = age_w(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_en,
    input  logic [AGE_W-1:0] touch_idx,
    output logic [AGE_W-1:0] victim_idx
);

    logic [AGE_W-1:0] age [NUM_LINES];

    // Age update: touched line becomes youngest, younger lines age by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LINES; k++) age[k] <= AGE_W'(k);
        end else if (touch_en) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                if (AGE_W'(k) == touch_idx)
                    age[k] <= '0;
                else if (age[k] < age[touch_idx])
                    age[k] <= age[k] + AGE_W'(1);
            end
        end
    end

    // Victim is the unique line holding the oldest age.
    always_comb begin
        victim_idx = '0;
        for (int k = 0; k < NUM_LINES; k++)
            if (age[k] == AGE_W'(NUM_LINES - 1)) victim_idx = AGE_W'(k);
    end

endmodule

// File: rtl/fa_cache_array.sv
// Fully associative cache line array with multi-port combinational reads,
// LRU replacement, eviction reporting and an optional dirty-line flush scan.
// Optional feature macro: FA_CACHE_FLUSH_EN (defined -> flush scan present).
module fa_cache_array
    import fa_cache_pkg::*;
#(
    parameter int NUM_LINES   = 8,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_PORT_NUM = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [RD_PORT_NUM-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_PORT_NUM-1:0]                 rd_hit,
    output logic [RD_PORT_NUM-1:0][DATA_WIDTH-1:0] rd_data_out,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data_in,
    input  logic                                  wr_dirty_in,
    output logic                                  wr_ready,
    output logic                                  wr_hit,
    output logic                                  evict,
    output logic [ADDR_WIDTH-1:0]                 evicted_addr,
    output logic [DATA_WIDTH-1:0]                 evicted_data,
    output logic                                  evicted_dirty,
    input  logic                                  flush_req,
    output logic                                  flush_valid,
    input  logic                                  flush_ready,
    output logic [ADDR_WIDTH-1:0]                 flush_addr,
    output logic [DATA_WIDTH-1:0]                 flush_data,
    output logic                                  flush_done,
    output logic [$clog2(NUM_LINES):0]            dbg_occupancy
);

    localparam int IDX_W = age_w(NUM_LINES);
    localparam int OCC_W = $clog2(NUM_LINES) + 1;

    logic [NUM_LINES-1:0]  valid_q, dirty_q;
    logic [ADDR_WIDTH-1:0] tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

    logic [IDX_W-1:0] rd0_idx, hit_idx, free_idx, victim_idx, wr_idx, scan_idx;
    logic             has_free, wr_acc, touch_en, flush_clr;
    logic [IDX_W-1:0] touch_idx;

    // Read lookup on registered state; tags of valid lines are unique.
    always_comb begin
        rd_hit      = '0;
        rd_data_out = '0;
        rd0_idx     = '0;
        for (int p = 0; p < RD_PORT_NUM; p++) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                if (valid_q[k] && tag_q[k] == rd_addr[p]) begin
                    rd_hit[p]      = 1'b1;
                    rd_data_out[p] = data_q[k];
                    if (p == 0) rd0_idx = IDX_W'(k);
                end
            end
        end
    end

    // Write lookup: matching line and lowest-index free line.
    always_comb begin
        wr_hit   = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int k = NUM_LINES - 1; k >= 0; k--) begin
            if (valid_q[k] && tag_q[k] == wr_addr) begin
                wr_hit  = 1'b1;
                hit_idx = IDX_W'(k);
            end
            if (!valid_q[k]) free_idx = IDX_W'(k);
        end
    end

    assign has_free = ~&valid_q;
    assign wr_acc   = wr_en & wr_ready;
    assign wr_idx   = wr_hit ? hit_idx : (has_free ? free_idx : victim_idx);
    assign evict    = wr_acc & ~wr_hit & ~has_free;

    assign evicted_addr  = evict ? tag_q[victim_idx]   : '0;
    assign evicted_data  = evict ? data_q[victim_idx]  : '0;
    assign evicted_dirty = evict ? dirty_q[victim_idx] : 1'b0;

    // A write outranks a port-0 read hit for the single LRU touch per cycle.
    assign touch_en  = wr_acc | rd_hit[0];
    assign touch_idx = wr_acc ? wr_idx : rd0_idx;

    fa_cache_lru #(.NUM_LINES(NUM_LINES)) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch_en   (touch_en),
        .touch_idx  (touch_idx),
        .victim_idx (victim_idx)
    );

    // Line storage: write/fill, plus dirty clear when a flush beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int k = 0; k < NUM_LINES; k++) begin
                tag_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            if (wr_acc) begin
                valid_q[wr_idx] <= 1'b1;
                dirty_q[wr_idx] <= wr_dirty_in | wr_hit;
                tag_q[wr_idx]   <= wr_addr;
                data_q[wr_idx]  <= wr_data_in;
            end
            if (flush_clr) dirty_q[scan_idx] <= 1'b0;
        end
    end

    // Population count of valid lines.
    always_comb begin
        dbg_occupancy = '0;
        for (int k = 0; k < NUM_LINES; k++)
            dbg_occupancy = dbg_occupancy + OCC_W'(valid_q[k]);
    end

`ifdef FA_CACHE_FLUSH_EN
    flush_state_e     state_q, state_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic             line_done;

    assign scan_idx = scan_q;

    // Flush controller state and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            scan_q  <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
        end
    end

    // Flush next-state and outputs; writes are only accepted in IDLE.
    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        wr_ready    = 1'b0;
        flush_valid = 1'b0;
        flush_addr  = '0;
        flush_data  = '0;
        flush_done  = 1'b0;
        flush_clr   = 1'b0;
        line_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_SCAN;
                    scan_d  = '0;
                end else begin
                    wr_ready = 1'b1;
                end
            end
            ST_SCAN: begin
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    flush_valid = 1'b1;
                    flush_addr  = tag_q[scan_q];
                    flush_data  = data_q[scan_q];
                    flush_clr   = flush_ready;
                    line_done   = flush_ready;
                end else begin
                    line_done = 1'b1;
                end
                if (line_done) begin
                    scan_d = scan_q + IDX_W'(1);
                    if (scan_q == IDX_W'(NUM_LINES - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    logic flush_unused;

    assign flush_unused = flush_req ^ flush_ready;
    assign wr_ready     = 1'b1;
    assign flush_valid  = 1'b0;
    assign flush_addr   = '0;
    assign flush_data   = '0;
    assign flush_done   = 1'b0;
    assign flush_clr    = 1'b0;
    assign scan_idx     = '0;
`endif

endmodule

// File: tb/tb_fa_cache_array.sv
// Self-checking bench for fa_cache_array against a queue-based LRU model.
module tb_fa_cache_array;

    localparam int N  = 8;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int RP = 2;
`ifdef FA_CACHE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [RP-1:0][AW-1:0]   rd_addr;
    logic [RP-1:0]           rd_hit;
    logic [RP-1:0][DW-1:0]   rd_data_out;
    logic                    wr_en, wr_dirty_in, wr_ready, wr_hit;
    logic [AW-1:0]           wr_addr, evicted_addr, flush_addr;
    logic [DW-1:0]           wr_data_in, evicted_data, flush_data;
    logic                    evict, evicted_dirty;
    logic                    flush_req, flush_valid, flush_ready, flush_done;
    logic [$clog2(N):0]      dbg_occupancy;

    fa_cache_array #(.NUM_LINES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORT_NUM(RP)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data_out(rd_data_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_in(wr_data_in), .wr_dirty_in(wr_dirty_in),
        .wr_ready(wr_ready), .wr_hit(wr_hit), .evict(evict), .evicted_addr(evicted_addr),
        .evicted_data(evicted_data), .evicted_dirty(evicted_dirty), .flush_req(flush_req),
        .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_addr(flush_addr),
        .flush_data(flush_data), .flush_done(flush_done), .dbg_occupancy(dbg_occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: line contents plus a recency list (front = most recent).
    bit            m_valid [N];
    bit            m_dirty [N];
    logic [AW-1:0] m_tag   [N];
    logic [DW-1:0] m_data  [N];
    int            lru_q[$];
    int            m_mode;      // 0 idle, 1 scanning, 2 done pulse
    int            m_sidx;
    logic [AW-1:0] beats[$];
    int            done_cnt;

    function automatic void m_reset();
        lru_q = {};
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 0; m_dirty[k] = 0; m_tag[k] = '0; m_data[k] = '0;
            lru_q.push_back(k);
        end
        m_mode = 0;
        m_sidx = 0;
    endfunction

    function automatic int m_find(input logic [AW-1:0] a);
        for (int k = 0; k < N; k++) if (m_valid[k] && m_tag[k] == a) return k;
        return -1;
    endfunction

    function automatic void m_touch(input int k);
        for (int i = 0; i < lru_q.size(); i++)
            if (lru_q[i] == k) begin lru_q.delete(i); break; end
        lru_q.push_front(k);
    endfunction

    // One clock: compare all outputs against the model, then advance the model.
    task automatic step();
        int rh0, rh, wh, tgt, vic, occ;
        bit acc, ev, fv, rdy;
        #1;
        if (!rst_n) m_reset();
        rdy = FLUSH_EN ? (m_mode == 0 && !flush_req) : 1'b1;
        rh0 = m_find(rd_addr[0]);
        for (int p = 0; p < RP; p++) begin
            rh = m_find(rd_addr[p]);
            check("rd_hit", 64'(rd_hit[p]), 64'(rh >= 0));
            check("rd_data", rd_data_out[p], (rh >= 0) ? m_data[rh] : 64'h0);
        end
        occ = 0;
        for (int k = 0; k < N; k++) occ += int'(m_valid[k]);
        wh  = m_find(wr_addr);
        acc = wr_en && rdy;
        vic = lru_q[lru_q.size() - 1];
        ev  = acc && wh < 0 && occ == N;
        fv  = FLUSH_EN && m_mode == 1 && m_valid[m_sidx] && m_dirty[m_sidx];
        check("wr_ready", 64'(wr_ready), 64'(rdy));
        check("wr_hit", 64'(wr_hit), 64'(wh >= 0));
        check("evict", 64'(evict), 64'(ev));
        check("evicted_addr", 64'(evicted_addr), ev ? 64'(m_tag[vic]) : 64'h0);
        check("evicted_data", evicted_data, ev ? m_data[vic] : 64'h0);
        check("evicted_dirty", 64'(evicted_dirty), ev ? 64'(m_dirty[vic]) : 64'h0);
        check("occupancy", 64'(dbg_occupancy), 64'(occ));
        check("flush_valid", 64'(flush_valid), 64'(fv));
        check("flush_addr", 64'(flush_addr), fv ? 64'(m_tag[m_sidx]) : 64'h0);
        check("flush_data", flush_data, fv ? m_data[m_sidx] : 64'h0);
        check("flush_done", 64'(flush_done), 64'(FLUSH_EN && m_mode == 2));
        if (flush_valid && flush_ready) beats.push_back(flush_addr);
        if (flush_done) done_cnt++;
        if (rst_n) begin
            if (acc) begin
                if (wh >= 0) tgt = wh;
                else if (occ < N) begin
                    tgt = 0;
                    for (int k = N - 1; k >= 0; k--) if (!m_valid[k]) tgt = k;
                end else tgt = vic;
                m_valid[tgt] = 1;
                m_dirty[tgt] = wr_dirty_in || (wh >= 0);
                m_tag[tgt]   = wr_addr;
                m_data[tgt]  = wr_data_in;
                m_touch(tgt);
            end else if (rh0 >= 0) begin
                m_touch(rh0);
            end
            if (FLUSH_EN) begin
                case (m_mode)
                    0: if (flush_req) begin m_mode = 1; m_sidx = 0; end
                    1: if (!fv || flush_ready) begin
                           if (fv) m_dirty[m_sidx] = 0;
                           if (m_sidx == N - 1) m_mode = 2; else m_sidx++;
                       end
                    default: m_mode = 0;
                endcase
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit dty);
        wr_en = 1'b1; wr_addr = a; wr_data_in = d; wr_dirty_in = dty;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int stall, guard;
        rst_n = 1'b0; wr_en = 0; wr_addr = '0; wr_data_in = '0; wr_dirty_in = 0;
        flush_req = 0; flush_ready = 0;
        rd_addr[0] = 13'h1FFF; rd_addr[1] = 13'h1FFE;
        beats = {}; done_cnt = 0;
        m_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Two clean fills land in lines 0 and 1.
        wr(13'h010, 64'h10, 0);
        wr(13'h011, 64'h11, 0);
        #1 check("occ_after_two_fills", 64'(dbg_occupancy), 64'd2);

        // Full cache, refresh 0x100 via port 0, next miss evicts 0x101.
        do_reset();
        for (int k = 0; k < N; k++) wr(13'h100 + 13'(k), 64'h1000 + 64'(k), 0);
        rd_addr[0] = 13'h100;
        step();
        rd_addr[0] = 13'h1FFF;
        wr_en = 1; wr_addr = 13'h200; wr_data_in = 64'h2000; wr_dirty_in = 0;
        #1;
        check("lru_evict", 64'(evict), 64'd1);
        check("lru_victim_addr", 64'(evicted_addr), 64'h101);
        step();
        wr_en = 0;

        // Clean rewrite of a resident line is a hit and leaves it dirty.
        wr_en = 1; wr_addr = 13'h100; wr_data_in = 64'h1100; wr_dirty_in = 0;
        #1 check("rewrite_hit", 64'(wr_hit), 64'd1);
        step();
        wr_en = 0;
        for (int i = 0; i < N; i++) begin
            wr_en = 1; wr_addr = 13'h400 + 13'(i); wr_data_in = 64'h4000 + 64'(i); wr_dirty_in = 0;
            #1;
            if (i == N - 1) begin
                check("dirty_victim_addr", 64'(evicted_addr), 64'h100);
                check("dirty_victim_flag", 64'(evicted_dirty), 64'd1);
            end
            step();
        end
        wr_en = 0;

        // No same-cycle forwarding from write to read.
        wr_en = 1; wr_addr = 13'h300; wr_data_in = 64'hAA; wr_dirty_in = 0;
        rd_addr[0] = 13'h300;
        #1 check("no_forward_hit", 64'(rd_hit[0]), 64'd0);
        step();
        wr_en = 0;
        #1;
        check("read_after_write_hit", 64'(rd_hit[0]), 64'd1);
        check("read_after_write_data", rd_data_out[0], 64'hAA);
        step();
        rd_addr[0] = 13'h1FFF;

`ifdef FA_CACHE_FLUSH_EN
        // Flush with lines 2 and 5 dirty, first beat stalled three cycles.
        do_reset();
        for (int k = 0; k < N; k++) wr(13'h500 + 13'(k), 64'h5000 + 64'(k), (k == 2 || k == 5));
        beats = {}; done_cnt = 0; stall = 0;
        flush_req = 1; step(); flush_req = 0;
        guard = 0;
        while (m_mode != 0 && guard < 40) begin
            if (m_mode == 1 && m_valid[m_sidx] && m_dirty[m_sidx] && stall < 3) begin
                flush_ready = 0; stall++;
            end else flush_ready = 1;
            step();
            guard++;
        end
        flush_ready = 0;
        check("flush_terminated", 64'(guard < 40), 64'd1);
        check("flush_beat_count", 64'(beats.size()), 64'd2);
        if (beats.size() == 2) begin
            check("flush_beat0", 64'(beats[0]), 64'h502);
            check("flush_beat1", 64'(beats[1]), 64'h505);
        end
        check("flush_done_count", 64'(done_cnt), 64'd1);

        // A second flush finds nothing dirty.
        beats = {};
        flush_req = 1; flush_ready = 1; step(); flush_req = 0;
        guard = 0;
        while (m_mode != 0 && guard < 40) begin step(); guard++; end
        check("reflush_no_beats", 64'(beats.size()), 64'd0);

        // Start a flush and park on a beat, ready for reset mid-scan.
        wr(13'h503, 64'h5333, 1);
        done_cnt = 0;
        flush_ready = 0;
        flush_req = 1; step(); flush_req = 0;
        guard = 0;
        while (!(m_mode == 1 && m_valid[m_sidx] && m_dirty[m_sidx]) && guard < 20) begin
            step(); guard++;
        end
        check("scan_reached_beat", 64'(flush_valid), 64'd1);
`endif

        // Asynchronous reset in the middle of activity.
        rst_n = 1'b0;
        #1;
        check("reset_flush_valid", 64'(flush_valid), 64'd0);
        check("reset_occupancy", 64'(dbg_occupancy), 64'd0);
        check("reset_wr_ready", 64'(wr_ready), 64'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("reset_no_done", 64'(done_cnt), 64'd0);

        // Randomized traffic over a small address pool to force hits and evictions.
        for (int c = 0; c < 600; c++) begin
            wr_en       = ($urandom_range(0, 1) == 1);
            wr_addr     = 13'h040 + 13'($urandom_range(0, 11));
            wr_data_in  = {$urandom(), $urandom()};
            wr_dirty_in = $urandom_range(0, 1) == 1;
            rd_addr[0]  = 13'h040 + 13'($urandom_range(0, 11));
            rd_addr[1]  = 13'h040 + 13'($urandom_range(0, 11));
            flush_req   = ($urandom_range(0, 15) == 0);
            flush_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
